// File: rtl/swap_reg_file_pkg.sv
// Shared definitions for the swap register file.
// Holds the default geometry and the swap FSM state encoding, which is
// also exposed on the swap_fsm debug state output so checkers can decode it.
package swap_reg_file_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 7;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int STATE_WIDTH        = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WR_A = 3'd2,
        ST_WR_B = 3'd3,
        ST_DONE = 3'd4
    } swap_state_t;

endpackage

// File: rtl/swap_reg_file_swap_fsm.sv
// swap_fsm: sequencer for the in-place exchange of two memory words.
//
// Handshake: start is a request, sampled only while the FSM is IDLE (a start
// seen in any other state is dropped, never queued). busy is high for the
// three cycles LOAD/WR_A/WR_B; done is a one-cycle pulse in DONE once both
// writes have committed. There is no ready: the host watches busy/done.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start, addr_a, addr_b swap request and the two locations (captured in IDLE)
//   rd_a, rd_b            memory contents at ra/rb, supplied by the top level
//   ra, rb                captured swap addresses (drive the top's lookups)
//   busy, done            host status
//   fsm_we, fsm_addr,     write-port request; the top gives the FSM the port
//   fsm_data              whenever fsm_we is high
//   state                 debug view of the current state encoding
module swap_fsm
    import swap_reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  addr_a,
    input  logic [ADDR_WIDTH-1:0]  addr_b,
    input  logic [DATA_WIDTH-1:0]  rd_a,
    input  logic [DATA_WIDTH-1:0]  rd_b,
    output logic [ADDR_WIDTH-1:0]  ra,
    output logic [ADDR_WIDTH-1:0]  rb,
    output logic                   busy,
    output logic                   done,
    output logic                   fsm_we,
    output logic [ADDR_WIDTH-1:0]  fsm_addr,
    output logic [DATA_WIDTH-1:0]  fsm_data,
    output logic [STATE_WIDTH-1:0] state
);

    swap_state_t           state_q;
    swap_state_t           state_d;
    logic [ADDR_WIDTH-1:0] ra_q;
    logic [ADDR_WIDTH-1:0] rb_q;
    logic [DATA_WIDTH-1:0] ta_q;
    logic [DATA_WIDTH-1:0] tb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            ta_q    <= '0;
            tb_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                ra_q <= addr_a;
                rb_q <= addr_b;
            end
            // Both words are snapshotted before either write so that the
            // exchange is immune to ra == rb and to write ordering.
            if (state_q == ST_LOAD) begin
                ta_q <= rd_a;
                tb_q <= rd_b;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        fsm_we   = 1'b0;
        fsm_addr = ra_q;
        fsm_data = tb_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                busy    = 1'b1;
                state_d = ST_WR_A;
            end
            ST_WR_A: begin
                busy     = 1'b1;
                fsm_we   = 1'b1;
                fsm_addr = ra_q;
                fsm_data = tb_q;
                state_d  = ST_WR_B;
            end
            ST_WR_B: begin
                busy     = 1'b1;
                fsm_we   = 1'b1;
                fsm_addr = rb_q;
                fsm_data = ta_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ra    = ra_q;
    assign rb    = rb_q;
    assign state = state_q;

endmodule

// File: rtl/swap_reg_file.sv
// swap_reg_file: register file with one synchronous write port, two
// combinational read ports and a built-in two-location swap engine.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//                              (resets the swap engine only, not memory)
//   we, address_w, data_w      host write port (dropped while busy)
//   address_r0/data_r0         read port 0, zero latency
//   address_r1/data_r1         read port 1, zero latency
//   start, addr_a, addr_b      swap request
//   busy, done                 swap status
module swap_reg_file
    import swap_reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] address_r0,
    output logic [DATA_WIDTH-1:0] data_r0,
    input  logic [ADDR_WIDTH-1:0] address_r1,
    output logic [DATA_WIDTH-1:0] data_r1,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_WIDTH-1:0]  ra;
    logic [ADDR_WIDTH-1:0]  rb;
    logic                   fsm_we;
    logic [ADDR_WIDTH-1:0]  fsm_addr;
    logic [DATA_WIDTH-1:0]  fsm_data;
    logic [STATE_WIDTH-1:0] fsm_state;

    logic                   host_we;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;

    swap_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_swap_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .rd_a     (mem[ra]),
        .rd_b     (mem[rb]),
        .ra       (ra),
        .rb       (rb),
        .busy     (busy),
        .done     (done),
        .fsm_we   (fsm_we),
        .fsm_addr (fsm_addr),
        .fsm_data (fsm_data),
        .state    (fsm_state)
    );

    // The host owns the write port whenever the engine is not busy
    // (IDLE and the DONE status cycle). A write issued together with start
    // lands at the same edge that leaves IDLE, so LOAD already sees it.
    assign host_we = we && !reset &&
                     (fsm_state == ST_IDLE || fsm_state == ST_DONE);

    assign wr_en   = fsm_we || host_we;
    assign wr_addr = fsm_we ? fsm_addr : address_w;
    assign wr_data = fsm_we ? fsm_data : data_w;

    // Memory has no reset: contents survive a reset, including the partial
    // state left by a swap aborted between its two writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign data_r0 = mem[address_r0];
    assign data_r1 = mem[address_r1];

endmodule

// File: tb/tb_swap_reg_file.sv
module tb_swap_reg_file;

  localparam int AW = 7;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------- DUT ----------------
  logic          we = 1'b0;
  logic [AW-1:0] address_w = '0;
  logic [DW-1:0] data_w = '0;
  logic [AW-1:0] address_r0 = '0;
  logic [DW-1:0] data_r0;
  logic [AW-1:0] address_r1 = '0;
  logic [DW-1:0] data_r1;
  logic          start = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic          busy;
  logic          done;

  swap_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .address_w  (address_w),
    .data_w     (data_w),
    .address_r0 (address_r0),
    .data_r0    (data_r0),
    .address_r1 (address_r1),
    .data_r1    (data_r1),
    .start      (start),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] model [1 << AW];
  bit            active = 0;   // a swap has been accepted since last reset
  int            busy_lo = 0;  // first edge count with busy high
  int            done_at = 0;  // edge count of the done cycle

  logic [DW-1:0] exp_q [$];    // expected read-port data, in pairs
  int            done_q [$];   // expected edge count of each done pulse
  bit            rd_chk = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic bit exp_busy_now();
    return active && edge_cnt >= busy_lo && edge_cnt <= busy_lo + 2;
  endfunction

  function automatic bit can_start();
    return !active || edge_cnt > done_at;
  endfunction

  // ---------------- driver tasks (entered just after a posedge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                       input bit st, input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [DW-1:0] tmp;
    if (w && !exp_busy_now()) model[aw] = dw;
    if (st && can_start()) begin
      tmp = model[a];
      model[a] = model[b];
      model[b] = tmp;
      active  = 1;
      busy_lo = edge_cnt + 1;
      done_at = edge_cnt + 4;
      done_q.push_back(done_at);
    end
    we = w; address_w = aw; data_w = dw;
    start = st; addr_a = a; addr_b = b;
    tick();
    we = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 && active && edge_cnt <= done_at; i++) tick();
  endtask

  task automatic check_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    address_r0 = a0;
    address_r1 = a1;
    exp_q.push_back(model[a0]);
    exp_q.push_back(model[a1]);
    rd_chk = 1;
    tick();
    rd_chk = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [DW-1:0] e0, e1;
    chk("busy", {31'b0, busy}, {31'b0, exp_busy_now()});
    if (done_q.size() > 0 && edge_cnt > done_q[0]) begin
      chk("done_missing", 32'd0, 32'd1);
      void'(done_q.pop_front());
    end
    if (done) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else chk("done_cycle", edge_cnt, done_q.pop_front());
    end
    if (rd_chk) begin
      if (exp_q.size() < 2) chk("rd_queue", exp_q.size(), 2);
      else begin
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        chk("data_r0", data_r0, e0);
        chk("data_r1", data_r1, e1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] old_b;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    tick();

    // preload every location
    for (int i = 0; i < (1 << AW); i++) drive(1, i[AW-1:0], DW'($urandom_range(0, 255)), 0, '0, '0);

    // basic write / read
    drive(1, 7'h05, 8'hA5, 0, '0, '0);
    drive(1, 7'h7F, 8'h3C, 0, '0, '0);
    drive(1, 7'h10, 8'h11, 0, '0, '0);
    check_rd(7'h05, 7'h7F);

    // swap with blocked write and repeat start during busy
    drive(0, '0, '0, 1, 7'h05, 7'h7F);
    tick();
    drive(1, 7'h10, 8'hFF, 1, 7'h05, 7'h7F);
    idle(4);
    check_rd(7'h05, 7'h7F);
    check_rd(7'h10, 7'h10);

    // same address
    drive(1, 7'h20, 8'h77, 0, '0, '0);
    drive(0, '0, '0, 1, 7'h20, 7'h20);
    idle(5);
    check_rd(7'h20, 7'h05);

    // reset between the two write commits
    drive(1, 7'h01, 8'h11, 0, '0, '0);
    drive(1, 7'h02, 8'h22, 0, '0, '0);
    old_b = model[2];
    drive(0, '0, '0, 1, 7'h01, 7'h02);   // now in LOAD
    tick();                              // WR_A
    tick();                              // WR_B, mem[1] already written
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    model[2] = old_b;
    done_q.delete();
    active = 0;
    tick();
    reset = 1'b0;
    idle(2);
    check_rd(7'h01, 7'h02);
    drive(0, '0, '0, 1, 7'h01, 7'h03);
    idle(5);
    check_rd(7'h01, 7'h03);

    // simultaneous start + write
    drive(1, 7'h31, 8'h44, 0, '0, '0);
    drive(1, 7'h30, 8'h99, 1, 7'h30, 7'h31);
    idle(5);
    check_rd(7'h30, 7'h31);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a, b;
      a = AW'($urandom_range(0, 127));
      b = ($urandom_range(0, 7) == 0) ? a : AW'($urandom_range(0, 127));
      drive($urandom_range(0, 1), AW'($urandom_range(0, 127)), DW'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0, a, b);
      for (int k = $urandom_range(0, 5); k > 0; k--)
        drive($urandom_range(0, 1), AW'($urandom_range(0, 127)), DW'($urandom_range(0, 255)),
              $urandom_range(0, 4) == 0, AW'($urandom_range(0, 127)), AW'($urandom_range(0, 127)));
      wait_idle();
      check_rd(a, b);
    end

    idle(6);
    chk("done_outstanding", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
